// File: rtl/insertion_sort_param.sv
// In-place insertion-sort buffer: push/pop stack of DEPTH x DW entries with an on-command stable sort.
// Define INSERTION_SORT_SIGNED_EN to compare keys as two's-complement values instead of unsigned.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for a command edge
// ST_CLEAR   | empty the buffer
// ST_PUSH    | write din on top, or flag overflow
// ST_POP     | read top into dout, or flag underflow
// ST_S_INIT  | latch sort order, start outer loop at j=1
// ST_J_CHK   | outer loop test, fetch key = A[j]
// ST_I_INIT  | inner index i = j-1
// ST_I_CHK   | decide whether A[i] must move up
// ST_I_SHIFT | A[i+1] = A[i], step i down
// ST_I_END   | drop key into A[i+1], advance j
// ST_S_DONE  | report sort completion
module insertion_sort_param #(
    parameter int DW    = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enable,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic          sort,
    input  logic          descend,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          idle,
    output logic          done,
    output logic          err
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_CLEAR, ST_PUSH, ST_POP, ST_S_INIT, ST_J_CHK,
        ST_I_INIT, ST_I_CHK, ST_I_SHIFT, ST_I_END, ST_S_DONE
    } state_t;

    localparam logic [AW:0]   ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A = AW'(1);
    localparam logic [AW:0]   FULLC = (AW+1)'(DEPTH);

    state_t          state_q, state_d;
    logic [AW:0]     count_q, count_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [AW:0]     j_q, j_d;
    logic [AW:0]     i_q, i_d;
    logic [DW-1:0]   key_q, key_d;
    logic            order_q, order_d;
    logic [1:0]      h_push_q, h_pop_q, h_clear_q, h_sort_q;

    logic [DW-1:0]   mem_q [DEPTH];
    logic            we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;

    logic [DW-1:0]   a_i, a_j, a_top;
    logic            a_gt, a_lt;

    assign a_i   = mem_q[i_q[AW-1:0]];
    assign a_j   = mem_q[j_q[AW-1:0]];
    assign a_top = mem_q[count_q[AW-1:0] - ONE_A];

`ifdef INSERTION_SORT_SIGNED_EN
    assign a_gt = $signed(a_i) > $signed(key_q);
    assign a_lt = $signed(a_i) < $signed(key_q);
`else
    assign a_gt = a_i > key_q;
    assign a_lt = a_i < key_q;
`endif

    assign count = count_q;
    assign full  = (count_q == FULLC);
    assign empty = (count_q == '0);
    assign idle  = (state_q == ST_IDLE);
    assign dout  = dout_q;
    assign done  = done_q;
    assign err   = err_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dout_d  = dout_q;
        j_d     = j_q;
        i_d     = i_q;
        key_d   = key_q;
        order_d = order_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        case (state_q)
            ST_IDLE: begin
                // One command per visit; losing edges are simply dropped.
                if (h_clear_q == 2'b01)     state_d = ST_CLEAR;
                else if (h_push_q == 2'b01) state_d = ST_PUSH;
                else if (h_pop_q == 2'b01)  state_d = ST_POP;
                else if (h_sort_q == 2'b01) state_d = ST_S_INIT;
            end
            ST_CLEAR: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
            ST_PUSH: begin
                if (!full) begin
                    we      = 1'b1;
                    waddr   = count_q[AW-1:0];
                    wdata   = din;
                    count_d = count_q + ONE;
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_POP: begin
                if (!empty) begin
                    dout_d  = a_top;
                    count_d = count_q - ONE;
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_S_INIT: begin
                order_d = descend;
                j_d     = ONE;
                state_d = (count_q <= ONE) ? ST_S_DONE : ST_J_CHK;
            end
            ST_J_CHK: begin
                if (j_q == count_q) begin
                    state_d = ST_S_DONE;
                end else begin
                    key_d   = a_j;
                    state_d = ST_I_INIT;
                end
            end
            ST_I_INIT: begin
                i_d     = j_q - ONE;
                state_d = ST_I_CHK;
            end
            ST_I_CHK: begin
                // Strict compare keeps equal keys in arrival order.
                if (i_q == '1)                  state_d = ST_I_END;
                else if (order_q ? a_lt : a_gt) state_d = ST_I_SHIFT;
                else                            state_d = ST_I_END;
            end
            ST_I_SHIFT: begin
                we      = 1'b1;
                waddr   = AW'(i_q + ONE);
                wdata   = a_i;
                i_d     = i_q - ONE;
                state_d = ST_I_CHK;
            end
            ST_I_END: begin
                we      = 1'b1;
                waddr   = AW'(i_q + ONE);
                wdata   = key_q;
                j_d     = j_q + ONE;
                state_d = ST_J_CHK;
            end
            ST_S_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            j_q       <= '0;
            i_q       <= '0;
            key_q     <= '0;
            order_q   <= 1'b0;
            h_push_q  <= 2'b00;
            h_pop_q   <= 2'b00;
            h_clear_q <= 2'b00;
            h_sort_q  <= 2'b00;
        end else if (enable) begin
            state_q   <= state_d;
            count_q   <= count_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            err_q     <= err_d;
            j_q       <= j_d;
            i_q       <= i_d;
            key_q     <= key_d;
            order_q   <= order_d;
            h_push_q  <= {h_push_q[0], push};
            h_pop_q   <= {h_pop_q[0], pop};
            h_clear_q <= {h_clear_q[0], clear};
            h_sort_q  <= {h_sort_q[0], sort};
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (enable && we) mem_q[waddr] <= wdata;
    end

endmodule

// File: tb/tb_insertion_sort_param.sv
// Directed bench for insertion_sort_param (DEPTH=8, DW=16): table-driven sort cases plus corner sequences.
module tb_insertion_sort_param;

    logic        clk = 1'b0;
    logic        rstn, enable, push, pop, clear, sort, descend;
    logic [15:0] din, dout;
    logic [3:0]  count;
    logic        full, empty, idle, done, err;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    insertion_sort_param #(.DW(16), .DEPTH(8)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .push(push), .pop(pop),
        .clear(clear), .sort(sort), .descend(descend), .din(din), .dout(dout),
        .count(count), .full(full), .empty(empty), .idle(idle), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    typedef struct {
        logic [15:0] v [4];
        logic        desc;
        logic [15:0] e [4];
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && !idle; k++) tick(1);
        chk("idle_timeout", {31'd0, idle}, 32'd1);
    endtask

    task automatic cmd(input logic c_push, input logic c_pop, input logic c_clear,
                       input logic c_sort, input logic [15:0] d, input logic desc);
        din = d; descend = desc;
        push = c_push; pop = c_pop; clear = c_clear; sort = c_sort;
        tick(2);
        push = 1'b0; pop = 1'b0; clear = 1'b0; sort = 1'b0;
        wait_idle();
        tick(2);
    endtask

    task automatic do_push(input logic [15:0] d);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, d, descend);
    endtask

    task automatic do_pop();
        cmd(1'b0, 1'b1, 1'b0, 1'b0, din, descend);
    endtask

    task automatic do_clear();
        cmd(1'b0, 1'b0, 1'b1, 1'b0, din, descend);
    endtask

    task automatic do_sort(input logic desc);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, din, desc);
    endtask

    initial begin
        int d0, e0, lat;
        logic [15:0] last;

        tbl[0].v = '{16'd5, 16'd2, 16'd9, 16'd2}; tbl[0].desc = 1'b0; tbl[0].e = '{16'd9, 16'd5, 16'd2, 16'd2};
        tbl[1].v = '{16'd5, 16'd2, 16'd9, 16'd2}; tbl[1].desc = 1'b1; tbl[1].e = '{16'd2, 16'd2, 16'd5, 16'd9};
        tbl[2].v = '{16'd1, 16'd2, 16'd3, 16'd4}; tbl[2].desc = 1'b0; tbl[2].e = '{16'd4, 16'd3, 16'd2, 16'd1};
        tbl[3].v = '{16'd7, 16'd7, 16'd3, 16'd7}; tbl[3].desc = 1'b1; tbl[3].e = '{16'd3, 16'd7, 16'd7, 16'd7};

        rstn = 1'b0; enable = 1'b1; push = 1'b0; pop = 1'b0; clear = 1'b0; sort = 1'b0;
        descend = 1'b0; din = '0;
        tick(3);
        chk("rst_dout", {16'd0, dout}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rstn = 1'b1;
        tick(2);

        for (int t = 0; t < 4; t++) begin
            do_clear();
            for (int k = 0; k < 4; k++) do_push(tbl[t].v[k]);
            chk($sformatf("tbl%0d_count_pushed", t), {28'd0, count}, 32'd4);
            d0 = done_cnt;
            do_sort(tbl[t].desc);
            chk($sformatf("tbl%0d_done_pulses", t), done_cnt - d0, 32'd1);
            chk($sformatf("tbl%0d_count_sorted", t), {28'd0, count}, 32'd4);
            for (int k = 0; k < 4; k++) begin
                do_pop();
                chk($sformatf("tbl%0d_pop%0d", t, k), {16'd0, dout}, {16'd0, tbl[t].e[k]});
                chk($sformatf("tbl%0d_cnt%0d", t, k), {28'd0, count}, 32'(3 - k));
            end
            chk($sformatf("tbl%0d_empty", t), {31'd0, empty}, 32'd1);
        end

        // Fill to DEPTH, then overflow.
        do_clear();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fill_full_before%0d", k), {31'd0, full}, 32'd0);
            do_push(16'(16'h10 + k));
        end
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_count", {28'd0, count}, 32'd8);
        e0 = err_cnt;
        do_push(16'h55);
        chk("ovf_err", err_cnt - e0, 32'd1);
        chk("ovf_count", {28'd0, count}, 32'd8);
        for (int k = 7; k >= 0; k--) begin
            do_pop();
            chk($sformatf("drain%0d", k), {16'd0, dout}, 32'(16'h10 + k));
        end
        last = dout;
        e0 = err_cnt;
        do_pop();
        chk("unf_err", err_cnt - e0, 32'd1);
        chk("unf_dout", {16'd0, dout}, {16'd0, last});
        chk("unf_count", {28'd0, count}, 32'd0);

        // Sort with count=0: done two cycles after leaving IDLE.
        d0 = done_cnt;
        descend = 1'b0; sort = 1'b1;
        for (int k = 0; k < 10 && idle; k++) tick(1);
        chk("s0_left_idle", {31'd0, idle}, 32'd0);
        sort = 1'b0;
        lat = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            tick(1);
            lat++;
        end
        chk("s0_done_seen", {31'd0, done}, 32'd1);
        chk("s0_latency_le3", {31'd0, (lat <= 3)}, 32'd1);
        wait_idle();
        tick(2);
        chk("s0_done_once", done_cnt - d0, 32'd1);
        chk("s0_count", {28'd0, count}, 32'd0);

        // Sort with count=1.
        do_push(16'd42);
        d0 = done_cnt;
        do_sort(1'b1);
        chk("s1_done", done_cnt - d0, 32'd1);
        chk("s1_count", {28'd0, count}, 32'd1);
        do_pop();
        chk("s1_pop", {16'd0, dout}, 32'd42);

        // Clear beats a coincident push.
        do_push(16'd1); do_push(16'd2);
        cmd(1'b1, 1'b0, 1'b1, 1'b0, 16'd77, 1'b0);
        chk("clr_push_count", {28'd0, count}, 32'd0);

        // Push edge during a sort is discarded.
        do_push(16'd5); do_push(16'd2); do_push(16'd9); do_push(16'd2);
        d0 = done_cnt;
        descend = 1'b0; sort = 1'b1;
        tick(2);
        sort = 1'b0;
        tick(1);
        din = 16'd99; push = 1'b1;
        tick(2);
        push = 1'b0;
        wait_idle();
        tick(2);
        chk("midsort_done", done_cnt - d0, 32'd1);
        chk("midsort_count", {28'd0, count}, 32'd4);
        do_pop();
        chk("midsort_top", {16'd0, dout}, 32'd9);

        // Pause with enable low mid-sort, then resume.
        do_clear();
        do_push(16'd5); do_push(16'd2); do_push(16'd9); do_push(16'd2);
        d0 = done_cnt;
        descend = 1'b0; sort = 1'b1;
        tick(2);
        sort = 1'b0;
        tick(4);
        enable = 1'b0;
        tick(10);
        chk("pause_busy", {31'd0, idle}, 32'd0);
        chk("pause_count", {28'd0, count}, 32'd4);
        enable = 1'b1;
        wait_idle();
        tick(2);
        chk("pause_done", done_cnt - d0, 32'd1);
        do_pop(); chk("pause_pop0", {16'd0, dout}, 32'd9);
        do_pop(); chk("pause_pop1", {16'd0, dout}, 32'd5);
        do_pop(); chk("pause_pop2", {16'd0, dout}, 32'd2);
        do_pop(); chk("pause_pop3", {16'd0, dout}, 32'd2);

        // Signed versus unsigned key comparison.
        do_clear();
        do_push(16'h0003); do_push(16'hFFFE); do_push(16'h0001);
        do_sort(1'b0);
`ifdef INSERTION_SORT_SIGNED_EN
        do_pop(); chk("sgn_pop0", {16'd0, dout}, 32'h0003);
        do_pop(); chk("sgn_pop1", {16'd0, dout}, 32'h0001);
        do_pop(); chk("sgn_pop2", {16'd0, dout}, 32'hFFFE);
`else
        do_pop(); chk("sgn_pop0", {16'd0, dout}, 32'hFFFE);
        do_pop(); chk("sgn_pop1", {16'd0, dout}, 32'h0003);
        do_pop(); chk("sgn_pop2", {16'd0, dout}, 32'h0001);
`endif

        // Reset mid-sort aborts with count=0.
        do_push(16'd4); do_push(16'd3); do_push(16'd2);
        descend = 1'b0; sort = 1'b1;
        tick(2);
        sort = 1'b0;
        tick(3);
        rstn = 1'b0;
        #1;
        chk("abort_count", {28'd0, count}, 32'd0);
        chk("abort_idle", {31'd0, idle}, 32'd1);
        chk("abort_dout", {16'd0, dout}, 32'd0);
        tick(2);
        rstn = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
